// File: rtl/tsp_tour_eval_if.sv
// Handshake and RAM-port bundle between the TSP solver and the tour evaluator.
// The master side is the solver (start, RAM read data); the slave side is the evaluator.
interface tsp_tour_eval_if #(
  parameter int IDX_W   = 6,
  parameter int COORD_W = 8,
  parameter int LEN_W   = 19
);
  logic               start;
  logic               busy;
  logic [IDX_W-1:0]   path_addr;
  logic [IDX_W-1:0]   path_data;
  logic [IDX_W-1:0]   coord_addr;
  logic [COORD_W-1:0] coord_x;
  logic [COORD_W-1:0] coord_y;
  logic               done;
  logic [LEN_W-1:0]   length;
  logic [LEN_W-1:0]   best_len;
  logic               best_valid;
  logic               improved;

  modport master (
    output start, path_data, coord_x, coord_y,
    input  busy, path_addr, coord_addr, done, length, best_len, best_valid, improved
  );

  modport slave (
    input  start, path_data, coord_x, coord_y,
    output busy, path_addr, coord_addr, done, length, best_len, best_valid, improved
  );
endinterface

// File: rtl/tsp_tour_eval.sv
// Scores one closed TSP tour (Manhattan, saturating) in N+4 cycles from start; start is ignored while busy/finishing.
// Optional best-length tracking is enabled by defining TSP_EVAL_BEST_EN.
module tsp_tour_eval #(
  parameter int N       = 64,
  parameter int IDX_W   = 6,
  parameter int COORD_W = 8,
  parameter int LEN_W   = 19
) (
  input  logic           clk,
  input  logic           rst,
  tsp_tour_eval_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  localparam logic [IDX_W:0] K_LAST = (IDX_W+1)'(N);

  state_t             state_q, state_d;
  logic [IDX_W:0]     k_q, k_d;
  logic               drain_q, drain_d;
  logic [IDX_W-1:0]   path_addr_q, path_addr_d;
  logic               pd_vld_q, pd_vld_d;
  logic               pd_first_q, pd_first_d;
  logic               cd_vld_q, cd_vld_d;
  logic               cd_first_q, cd_first_d;
  logic [COORD_W-1:0] prev_x_q, prev_x_d;
  logic [COORD_W-1:0] prev_y_q, prev_y_d;
  logic [LEN_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [COORD_W-1:0] dx, dy;
  logic [COORD_W:0]   term;
  logic [LEN_W:0]     sum;
  logic [LEN_W-1:0]   acc_step;

`ifdef TSP_EVAL_BEST_EN
  logic [LEN_W-1:0]   best_len_q, best_len_d;
  logic               best_valid_q, best_valid_d;
  logic               improved_q, improved_d;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    drain_d     = drain_q;
    path_addr_d = path_addr_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    acc_d       = acc_q;
    length_d    = length_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef TSP_EVAL_BEST_EN
    best_len_d   = best_len_q;
    best_valid_d = best_valid_q;
    improved_d   = 1'b0;
`endif

    // Two-stage lookup pipeline: path data, then coordinates.
    pd_vld_d   = (state_q == RUN);
    pd_first_d = (state_q == RUN) && (k_q == '0);
    cd_vld_d   = pd_vld_q;
    cd_first_d = pd_first_q;

    dx       = (bus.coord_x >= prev_x_q) ? bus.coord_x - prev_x_q : prev_x_q - bus.coord_x;
    dy       = (bus.coord_y >= prev_y_q) ? bus.coord_y - prev_y_q : prev_y_q - bus.coord_y;
    term     = {1'b0, dx} + {1'b0, dy};
    sum      = {1'b0, acc_q} + {{(LEN_W-COORD_W){1'b0}}, term};
    acc_step = sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];

    if (cd_vld_q) begin
      prev_x_d = bus.coord_x;
      prev_y_d = bus.coord_y;
      if (!cd_first_q) acc_d = acc_step;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          k_d         = '0;
          path_addr_d = '0;
          acc_d       = '0;
          busy_d      = 1'b1;
        end
      end
      RUN: begin
        // Issue k = N re-reads path[0] to close the tour.
        if (k_q == K_LAST) begin
          state_d     = DRAIN;
          drain_d     = 1'b0;
          path_addr_d = '0;
        end else begin
          k_d         = k_q + 1'b1;
          path_addr_d = ((k_q + 1'b1) == K_LAST) ? '0 : k_q[IDX_W-1:0] + 1'b1;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d  = FINISH;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          length_d = acc_d;
`ifdef TSP_EVAL_BEST_EN
          if (!best_valid_q || acc_d < best_len_q) begin
            best_len_d   = acc_d;
            best_valid_d = 1'b1;
            improved_d   = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      drain_q      <= 1'b0;
      path_addr_q  <= '0;
      pd_vld_q     <= 1'b0;
      pd_first_q   <= 1'b0;
      cd_vld_q     <= 1'b0;
      cd_first_q   <= 1'b0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      acc_q        <= '0;
      length_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef TSP_EVAL_BEST_EN
      best_len_q   <= {LEN_W{1'b1}};
      best_valid_q <= 1'b0;
      improved_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      drain_q      <= drain_d;
      path_addr_q  <= path_addr_d;
      pd_vld_q     <= pd_vld_d;
      pd_first_q   <= pd_first_d;
      cd_vld_q     <= cd_vld_d;
      cd_first_q   <= cd_first_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      acc_q        <= acc_d;
      length_q     <= length_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef TSP_EVAL_BEST_EN
      best_len_q   <= best_len_d;
      best_valid_q <= best_valid_d;
      improved_q   <= improved_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.length     = length_q;
  assign bus.path_addr  = path_addr_q;
  // The coordinate address is the path RAM output itself, so no extra cycle is spent.
  assign bus.coord_addr = pd_vld_q ? bus.path_data : '0;

`ifdef TSP_EVAL_BEST_EN
  assign bus.best_len   = best_len_q;
  assign bus.best_valid = best_valid_q;
  assign bus.improved   = improved_q;
`else
  assign bus.best_len   = {LEN_W{1'b1}};
  assign bus.best_valid = 1'b0;
  assign bus.improved   = 1'b0;
`endif

endmodule
